// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Holds the FSM state encoding, default width and product-width helper.
package mult_pkg;

  localparam int MULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One combinational shift-and-add iteration.
// Adds mcand when the multiplier LSB is set, then shifts both operands.
module shift_add_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [prod_w(WIDTH)-1:0] acc,
  input  logic [prod_w(WIDTH)-1:0] mcand,
  input  logic [WIDTH-1:0]         mplier,
  output logic [prod_w(WIDTH)-1:0] acc_nxt,
  output logic [prod_w(WIDTH)-1:0] mcand_nxt,
  output logic [WIDTH-1:0]         mplier_nxt
);

  // carry out of the add is dropped; the product never needs it
  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/shift_add_mult.sv
// Iterative shift-and-add unsigned multiplier with valid/ready handshakes.
// Define SHIFT_ADD_MULT_EARLY_TERM_EN to stop once the multiplier runs out of set bits.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [prod_w(WIDTH)-1:0] prod,
  output logic                     busy
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_n;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc_s;
  logic [PW-1:0]   mcand_s;
  logic [WIDTH-1:0] mplier_s;
  logic            last;

  shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc       (acc),
    .mcand     (mcand),
    .mplier    (mplier),
    .acc_nxt   (acc_s),
    .mcand_nxt (mcand_s),
    .mplier_nxt(mplier_s)
  );

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  assign last = (cnt == CNT_LAST) || (mplier_s == '0);
`else
  assign last = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = BUSY;
      BUSY:    if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_s;
          mcand  <= mcand_s;
          mplier <= mplier_s;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // in_ready is held low for the whole reset window
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign prod      = (state == DONE) ? acc : '0;

endmodule
